wb_clint: RTL

Core-local interruptor slave on the Wishbone IO bus. Decodes the 256-byte CLINT window at 0x20000C00, which the interconnect routes here with mask 0xFFFFFF00. Holds a free-running 64-bit mtime counter, a 64-bit mtimecmp compare register and the msip software-interrupt bit. Drives the machine timer and software interrupt lines to the core.

---
 rtl/wb_clint.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wb_clint.sv
// Core-local interruptor (CLINT) Wishbone slave: 64-bit mtime/mtimecmp, msip,
// and the machine timer and software interrupt lines.
module wb_clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 64;
    localparam int unsigned PW  = 16;
    localparam int unsigned IXW = 6;

    localparam logic [PW-1:0]  DIV_LAST    = PW'(TICK_DIV - 1);
    localparam logic [IXW-1:0] IDX_MSIP    = IXW'(0);
    localparam logic [IXW-1:0] IDX_CMP_LO  = IXW'(2);
    localparam logic [IXW-1:0] IDX_CMP_HI  = IXW'(3);
    localparam logic [IXW-1:0] IDX_TIME_LO = IXW'(4);
    localparam logic [IXW-1:0] IDX_TIME_HI = IXW'(5);

    logic [TW-1:0] mtime_q, mtime_d;
    logic [TW-1:0] mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          timer_irq_q, timer_irq_d;
    logic          soft_irq_q, soft_irq_d;

    logic [IXW-1:0] word_c;
    logic           req_c;
    logic           hit_c;
    logic           wr_c;
    logic           tick_c;
    logic [DW-1:0]  rdata_c;

    // Byte-lane merge of write data into an existing 32-bit word.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [3:0]    sel);
        logic [DW-1:0] r;
        r = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Address decode and pre-write read mux.
    always_comb begin
        word_c  = wb_adr_i[7:2];
        req_c   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
        hit_c   = 1'b1;
        rdata_c = '0;
        case (word_c)
            IDX_MSIP:    rdata_c = {31'b0, msip_q};
            IDX_CMP_LO:  rdata_c = mtimecmp_q[31:0];
            IDX_CMP_HI:  rdata_c = mtimecmp_q[63:32];
            IDX_TIME_LO: rdata_c = mtime_q[31:0];
            IDX_TIME_HI: rdata_c = mtime_q[63:32];
            default:     hit_c   = 1'b0;
        endcase
        wr_c = req_c & wb_we_i & hit_c;
    end

    // Prescaler, register updates, bus response and interrupt next-state.
    always_comb begin
        tick_c      = (presc_q == DIV_LAST);
        presc_d     = tick_c ? '0 : presc_q + PW'(1);
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        ack_d       = req_c & hit_c;
        err_d       = req_c & ~hit_c;
        dat_d       = (req_c & hit_c) ? rdata_c : '0;
        timer_irq_d = (mtime_q >= mtimecmp_q);
        soft_irq_d  = msip_q;

        // A bus write to either mtime half suppresses that cycle's increment.
        if (wr_c && (word_c == IDX_TIME_LO)) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i);
        end else if (wr_c && (word_c == IDX_TIME_HI)) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i);
        end else if (tick_c) begin
            mtime_d = mtime_q + TW'(1);
        end

        if (wr_c && (word_c == IDX_CMP_LO)) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
        end
        if (wr_c && (word_c == IDX_CMP_HI)) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        end
        if (wr_c && (word_c == IDX_MSIP) && wb_sel_i[0]) begin
            msip_d = wb_dat_i[0];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            presc_q     <= '0;
            dat_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            presc_q     <= presc_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            timer_irq_q <= timer_irq_d;
            soft_irq_q  <= soft_irq_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_rty_o    = 1'b0;
    assign timer_irq_o = timer_irq_q;
    assign soft_irq_o  = soft_irq_q;

    // Burst hints and undecoded address bits are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:8], wb_adr_i[1:0]};

endmodule
